rcv_packet_deserializer: RTL and testbench
==========================================

RCV_PACKET_DESERIALIZER -- requirements
Module: rcv_packet_deserializer

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 64, meaning the maximum number of data payload bytes per packet, excluding CRC16 (legal range 1..1024).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port shift_strobe, input, 1 bit: d_orig holds a valid decoded bit this cycle.
REQ-005 SHALL have port d_orig, input, 1 bit: decoded serial bit, transmitted LSB-first.
REQ-006 SHALL have port eop, input, 1 bit: end-of-packet, a single-cycle pulse.
REQ-007 SHALL have port rcv_pid, output, 8 bits: captured PID.
REQ-008 SHALL have port rcv_token, output, 11 bits: token field as {endp[3:0], addr[6:0]}.
REQ-009 SHALL have port rcv_crc5, output, 5 bits: captured token CRC5.
REQ-010 SHALL have port rcv_crc16, output, 16 bits: captured data CRC16.
REQ-011 SHALL have port data_byte, output, 8 bits: emitted payload byte.
REQ-012 SHALL have port data_byte_valid, output, 1 bit: one-cycle qualifier for data_byte.
REQ-013 SHALL have port byte_count, output, $clog2(MAX_BYTES+1) bits: payload bytes emitted in the current packet.
REQ-014 SHALL have port pkt_done, output, 1 bit: one-cycle pulse on a well-formed packet end.
REQ-015 SHALL have port pkt_err, output, 1 bit: one-cycle pulse on error detection.
REQ-016 SHALL have port busy, output, 1 bit: high when the FSM is in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, SYNC, PID, TOKEN, DATA, HSHK, ERR.
REQ-018 SHALL sample d_orig only when shift_strobe=1 and, per field, shift right with the new bit entering the MSB, so the first bit lands in bit 0.
REQ-019 SHALL go IDLE->SYNC on shift_strobe; that bit is the first sync bit.
REQ-020 SHALL go SYNC->PID after 8 sync bits; PID->{TOKEN, DATA, HSHK} after 8 PID bits, decoded as pid[1:0]=01 token, 11 data, 10 handshake.
REQ-021 SHALL treat a PID with pid[3:0] != ~pid[7:4], or pid[1:0]=00, as an error.
REQ-022 TOKEN SHALL shift 11 bits into rcv_token, then 5 bits into rcv_crc5; eop when exactly 16 token bits have been received -> pkt_done; otherwise -> error.
REQ-023 DATA SHALL keep a 24-bit sliding window; on each completed byte, once more than 16 bits are held, it SHALL emit the oldest byte on data_byte, pulsing data_byte_valid the next cycle and incrementing byte_count.
REQ-024 In DATA, eop with a byte-aligned bit count of at least 16 SHALL load the final 16 window bits into rcv_crc16 and pulse pkt_done; otherwise it SHALL be an error.
REQ-025 HSHK SHALL require eop before any further strobe; eop -> pkt_done, a strobe -> error.
REQ-026 Emitting byte MAX_BYTES+1 SHALL be an error, and that byte SHALL NOT be emitted.
REQ-027 eop in SYNC or PID SHALL be an error.
REQ-028 pkt_done and pkt_err SHALL assert one cycle after the eop or offending bit and be mutually exclusive.
REQ-029 Error caused by eop -> IDLE; any other error -> ERR, ignoring strobes until eop, then IDLE with no second pulse.
REQ-030 On simultaneous eop and shift_strobe, eop SHALL win and the bit SHALL be discarded.
REQ-031 Captured fields SHALL hold until overwritten; byte_count SHALL clear on IDLE->SYNC.
REQ-032 pkt_done/pkt_err -> IDLE, and a strobe in that same cycle SHALL be accepted as a new sync bit.

Reset
REQ-033 rst SHALL force IDLE asynchronously and zero every output, window and counter, including mid-packet.
REQ-034 The first strobe after rst deasserts SHALL start a new packet.

Configuration
REQ-035 With macro RCV_SYNC_CHECK_EN defined, the 8 sync bits SHALL be compared to 8'h80 and a mismatch SHALL be an error (-> ERR).
REQ-036 Without RCV_SYNC_CHECK_EN, the 8 sync bits SHALL be counted and discarded unchecked, with no comparator logic.

Verification
REQ-037 Sync 0x80, PID 0xD2, eop -> pkt_done pulse, rcv_pid=0xD2, byte_count=0, no data_byte_valid.
REQ-038 Sync, PID 0xE1, addr 0x05, endp 0x1, crc5 0x0A, eop -> rcv_token=11'h085, rcv_crc5=0x0A, pkt_done.
REQ-039 Sync, PID 0xC3, bytes 0x11 0x22 0x33, crc16 0xBEEF (LSB-first), eop -> three data_byte_valid pulses 0x11/0x22/0x33, rcv_crc16=0xBEEF, byte_count=3, pkt_done.
REQ-040 PID 0xD3 -> pkt_err once, ERR until eop, then IDLE; with MAX_BYTES=4 and 7 bytes -> 4 bytes emitted then pkt_err.
REQ-041 Sync 0x81 -> pkt_err with RCV_SYNC_CHECK_EN, pkt_done without it; rst mid-DATA -> all outputs 0, busy=0.

Source files
------------

// File: rtl/rcv_packet_deserializer.sv
// Receive-side packet deserializer: turns decoded serial bits into PID, token, data and CRC fields.
// Define RCV_SYNC_CHECK_EN to compare the received sync byte against 8'h80.
module rcv_packet_deserializer #(
  parameter int MAX_BYTES = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           shift_strobe,
  input  logic                           d_orig,
  input  logic                           eop,
  output logic [7:0]                     rcv_pid,
  output logic [10:0]                    rcv_token,
  output logic [4:0]                     rcv_crc5,
  output logic [15:0]                    rcv_crc16,
  output logic [7:0]                     data_byte,
  output logic                           data_byte_valid,
  output logic [$clog2(MAX_BYTES+1)-1:0] byte_count,
  output logic                           pkt_done,
  output logic                           pkt_err,
  output logic                           busy
);

  localparam int CNT_W = $clog2(MAX_BYTES + 1);
  localparam logic [CNT_W-1:0] BC_MAX = CNT_W'(MAX_BYTES);
  localparam logic [CNT_W-1:0] BC_ONE = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, SYNC, PID, TOKEN, DATA, HSHK, ERR} state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [1:0]       seen_q, seen_d;
  logic [23:0]      win_q, win_d;
  logic [7:0]       pid_q, pid_d;
  logic [10:0]      tok_q, tok_d;
  logic [4:0]       crc5_q, crc5_d;
  logic [15:0]      crc16_q, crc16_d;
  logic [7:0]       byte_q, byte_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] bc_q, bc_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [7:0]  pid_next;
  logic [23:0] win_next;
  logic        sync_ok;
  logic        win_lsb_unused;

  assign pid_next       = {d_orig, pid_q[7:1]};
  assign win_next       = {d_orig, win_q[23:1]};
  assign win_lsb_unused = win_q[0];

`ifdef RCV_SYNC_CHECK_EN
  logic [7:0] sync_q;
  logic [7:0] sync_next;
  logic       sync_lsb_unused;

  assign sync_next       = {d_orig, sync_q[7:1]};
  assign sync_ok         = (sync_next == 8'h80);
  assign sync_lsb_unused = sync_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 8'h00;
    end else if (shift_strobe && !eop && (state_q == IDLE || state_q == SYNC)) begin
      sync_q <= sync_next;
    end
  end
`else
  assign sync_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    win_d   = win_q;
    pid_d   = pid_q;
    tok_d   = tok_q;
    crc5_d  = crc5_q;
    crc16_d = crc16_q;
    byte_d  = byte_q;
    vld_d   = 1'b0;
    bc_d    = bc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    // eop always takes priority over a coincident strobe; the bit is dropped.
    unique case (state_q)
      IDLE: begin
        if (!eop && shift_strobe) begin
          state_d = SYNC;
          cnt_d   = 5'd1;
          bc_d    = '0;
        end
      end
      SYNC: begin
        if (eop) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (shift_strobe) begin
          if (cnt_q == 5'd7) begin
            cnt_d = 5'd0;
            if (sync_ok) begin
              state_d = PID;
            end else begin
              err_d   = 1'b1;
              state_d = ERR;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      PID: begin
        if (eop) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (shift_strobe) begin
          pid_d = pid_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d  = 5'd0;
            seen_d = 2'd0;
            if ((pid_next[3:0] != ~pid_next[7:4]) || (pid_next[1:0] == 2'b00)) begin
              err_d   = 1'b1;
              state_d = ERR;
            end else begin
              unique case (pid_next[1:0])
                2'b01:   state_d = TOKEN;
                2'b11:   state_d = DATA;
                default: state_d = HSHK;
              endcase
            end
          end
        end
      end
      TOKEN: begin
        if (eop) begin
          done_d  = (cnt_q == 5'd16);
          err_d   = (cnt_q != 5'd16);
          state_d = IDLE;
        end else if (shift_strobe) begin
          if (cnt_q == 5'd16) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q < 5'd11) begin
              tok_d = {d_orig, tok_q[10:1]};
            end else begin
              crc5_d = {d_orig, crc5_q[4:1]};
            end
          end
        end
      end
      DATA: begin
        if (eop) begin
          state_d = IDLE;
          if ((cnt_q[2:0] == 3'd0) && (seen_q >= 2'd2)) begin
            crc16_d = win_q[23:8];
            done_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (shift_strobe) begin
          win_d = win_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q[2:0] == 3'd7) begin
            if (seen_q != 2'd3) begin
              seen_d = seen_q + 2'd1;
            end
            // Only bytes older than the trailing 16 bits are payload; the rest may be CRC16.
            if (seen_q >= 2'd2) begin
              if (bc_q == BC_MAX) begin
                err_d   = 1'b1;
                state_d = ERR;
              end else begin
                byte_d = win_next[7:0];
                vld_d  = 1'b1;
                bc_d   = bc_q + BC_ONE;
              end
            end
          end
        end
      end
      HSHK: begin
        if (eop) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (shift_strobe) begin
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      ERR: begin
        if (eop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      seen_q  <= 2'd0;
      win_q   <= 24'h0;
      pid_q   <= 8'h00;
      tok_q   <= 11'h0;
      crc5_q  <= 5'h0;
      crc16_q <= 16'h0;
      byte_q  <= 8'h00;
      vld_q   <= 1'b0;
      bc_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      win_q   <= win_d;
      pid_q   <= pid_d;
      tok_q   <= tok_d;
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
      byte_q  <= byte_d;
      vld_q   <= vld_d;
      bc_q    <= bc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rcv_pid         = pid_q;
  assign rcv_token       = tok_q;
  assign rcv_crc5        = crc5_q;
  assign rcv_crc16       = crc16_q;
  assign data_byte       = byte_q;
  assign data_byte_valid = vld_q;
  assign byte_count      = bc_q;
  assign pkt_done        = done_q;
  assign pkt_err         = err_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_rcv_packet_deserializer.sv
// Scoreboard bench for rcv_packet_deserializer (MAX_BYTES=4): stimulus queues expectations, a monitor checks them.
module tb_rcv_packet_deserializer;

  localparam int MAXB  = 4;
  localparam int CNT_W = $clog2(MAXB + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             shift_strobe = 1'b0;
  logic             d_orig = 1'b0;
  logic             eop = 1'b0;
  logic [7:0]       rcv_pid;
  logic [10:0]      rcv_token;
  logic [4:0]       rcv_crc5;
  logic [15:0]      rcv_crc16;
  logic [7:0]       data_byte;
  logic             data_byte_valid;
  logic [CNT_W-1:0] byte_count;
  logic             pkt_done;
  logic             pkt_err;
  logic             busy;

  rcv_packet_deserializer #(.MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst), .shift_strobe(shift_strobe), .d_orig(d_orig), .eop(eop),
    .rcv_pid(rcv_pid), .rcv_token(rcv_token), .rcv_crc5(rcv_crc5), .rcv_crc16(rcv_crc16),
    .data_byte(data_byte), .data_byte_valid(data_byte_valid), .byte_count(byte_count),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    bit          chk_pid;
    logic [7:0]  pid;
    bit          chk_tok;
    logic [10:0] tok;
    logic [4:0]  crc5;
    bit          chk_crc16;
    logic [15:0] crc16;
    logic [7:0]  bc;
  } pkt_exp_t;

  pkt_exp_t   exp_q[$];
  logic [7:0] byte_q[$];
  pkt_exp_t   em;
  logic [7:0] eb;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_pkt(input bit is_err, input bit cp, input logic [7:0] pid,
                         input bit ct, input logic [10:0] tok, input logic [4:0] c5,
                         input bit cc, input logic [15:0] c16, input logic [7:0] bc);
    pkt_exp_t e;
    e.is_err = is_err; e.chk_pid = cp; e.pid = pid; e.chk_tok = ct; e.tok = tok;
    e.crc5 = c5; e.chk_crc16 = cc; e.crc16 = c16; e.bc = bc;
    exp_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the register updates.
  always @(negedge clk) begin
    if (pkt_done || pkt_err) begin
      check("done_err_exclusive", {31'b0, pkt_done & pkt_err}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_pkt_end: got done=%0b err=%0b, expected none at %0t", pkt_done, pkt_err, $time);
      end else begin
        em = exp_q.pop_front();
        check("pkt_err_flag", {31'b0, pkt_err}, {31'b0, em.is_err});
        check("byte_count", {{(32-CNT_W){1'b0}}, byte_count}, {24'b0, em.bc});
        if (em.chk_pid) check("rcv_pid", {24'b0, rcv_pid}, {24'b0, em.pid});
        if (em.chk_tok) begin
          check("rcv_token", {21'b0, rcv_token}, {21'b0, em.tok});
          check("rcv_crc5", {27'b0, rcv_crc5}, {27'b0, em.crc5});
        end
        if (em.chk_crc16) check("rcv_crc16", {16'b0, rcv_crc16}, {16'b0, em.crc16});
      end
    end
    if (data_byte_valid) begin
      if (byte_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_data_byte: got 0x%0h, expected no byte at %0t", data_byte, $time);
      end else begin
        eb = byte_q.pop_front();
        check("data_byte", {24'b0, data_byte}, {24'b0, eb});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send_bit(input logic b);
    shift_strobe = 1'b1; d_orig = b;
    @(posedge clk); #1;
    shift_strobe = 1'b0; d_orig = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits({8'h00, b}, 8);
  endtask

  task automatic send_eop();
    eop = 1'b1;
    @(posedge clk); #1;
    eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    idle(3);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_pid", {24'b0, rcv_pid}, 32'd0);
    check("rst_bc", {{(32-CNT_W){1'b0}}, byte_count}, 32'd0);
    check("rst_done", {31'b0, pkt_done}, 32'd0);
    check("rst_err", {31'b0, pkt_err}, 32'd0);
    check("rst_vld", {31'b0, data_byte_valid}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Handshake packet
    exp_pkt(0, 1, 8'hD2, 0, 0, 0, 0, 0, 0);
    send_byte(8'h80); send_byte(8'hD2);
    check("hshk_busy", {31'b0, busy}, 32'd1);
    send_eop(); idle(3);

    // Token packet: addr 0x05, endp 0x1, crc5 0x0A
    exp_pkt(0, 1, 8'hE1, 1, 11'h085, 5'h0A, 0, 0, 0);
    send_byte(8'h80); send_byte(8'hE1);
    send_bits(16'h0005, 7); send_bits(16'h0001, 4); send_bits(16'h000A, 5);
    send_eop(); idle(3);

    // Data packet: 0x11 0x22 0x33, crc16 0xBEEF
    byte_q.push_back(8'h11); byte_q.push_back(8'h22); byte_q.push_back(8'h33);
    exp_pkt(0, 1, 8'hC3, 0, 0, 0, 1, 16'hBEEF, 3);
    send_byte(8'h80); send_byte(8'hC3);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_bits(16'hBEEF, 16);
    send_eop(); idle(3);

    // Bad PID: one error, ERR until eop
    exp_pkt(1, 1, 8'hD3, 0, 0, 0, 0, 0, 0);
    send_byte(8'h80); send_byte(8'hD3);
    send_byte(8'hA5); idle(2);
    check("err_state_busy", {31'b0, busy}, 32'd1);
    send_eop(); idle(2);
    check("err_exit_busy", {31'b0, busy}, 32'd0);

    // Overflow: 7 bytes with MAX_BYTES=4
    byte_q.push_back(8'h01); byte_q.push_back(8'h02);
    byte_q.push_back(8'h03); byte_q.push_back(8'h04);
    exp_pkt(1, 1, 8'hC3, 0, 0, 0, 0, 0, 4);
    send_byte(8'h80); send_byte(8'hC3);
    for (int i = 1; i <= 7; i++) send_byte(8'(i));
    idle(2); send_eop(); idle(3);

    // Sync 0x81
`ifdef RCV_SYNC_CHECK_EN
    exp_pkt(1, 0, 0, 0, 0, 0, 0, 0, 0);
`else
    exp_pkt(0, 1, 8'hD2, 0, 0, 0, 0, 0, 0);
`endif
    send_byte(8'h81); send_byte(8'hD2);
    send_eop(); idle(3);

    // eop during PID
    exp_pkt(1, 0, 0, 0, 0, 0, 0, 0, 0);
    send_byte(8'h80); send_bits(16'h0002, 4);
    send_eop(); idle(1);
    check("pid_eop_busy", {31'b0, busy}, 32'd0);
    idle(2);

    // Token cut short at 15 bits
    exp_pkt(1, 1, 8'hE1, 0, 0, 0, 0, 0, 0);
    send_byte(8'h80); send_byte(8'hE1); send_bits(16'h1234, 15);
    send_eop(); idle(3);

    // Data ending off a byte boundary
    byte_q.push_back(8'hA1);
    exp_pkt(1, 1, 8'hC3, 0, 0, 0, 0, 0, 1);
    send_byte(8'h80); send_byte(8'hC3);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_bits(16'h0005, 3);
    send_eop(); idle(3);

    // Strobe after handshake PID
    exp_pkt(1, 1, 8'hD2, 0, 0, 0, 0, 0, 0);
    send_byte(8'h80); send_byte(8'hD2); send_bit(1'b1);
    idle(2); send_eop(); idle(3);

    // Coincident eop and strobe: eop wins
    exp_pkt(0, 1, 8'hD2, 0, 0, 0, 0, 0, 0);
    send_byte(8'h80); send_byte(8'hD2);
    eop = 1'b1; shift_strobe = 1'b1; d_orig = 1'b1;
    @(posedge clk); #1;
    eop = 1'b0; shift_strobe = 1'b0; d_orig = 1'b0;
    idle(3);

    // Back-to-back: next sync starts in the pkt_done cycle
    exp_pkt(0, 1, 8'hD2, 0, 0, 0, 0, 0, 0);
    exp_pkt(0, 1, 8'h5A, 0, 0, 0, 0, 0, 0);
    send_byte(8'h80); send_byte(8'hD2); send_eop();
    send_byte(8'h80); send_byte(8'h5A); send_eop();
    idle(3);

    // Reset mid-DATA
    byte_q.push_back(8'h5A);
    send_byte(8'h80); send_byte(8'hC3);
    send_byte(8'h5A); send_byte(8'h6B); send_byte(8'h7C); send_bits(16'h000F, 4);
    rst = 1'b1; #2;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_pid", {24'b0, rcv_pid}, 32'd0);
    check("mid_rst_token", {21'b0, rcv_token}, 32'd0);
    check("mid_rst_crc5", {27'b0, rcv_crc5}, 32'd0);
    check("mid_rst_crc16", {16'b0, rcv_crc16}, 32'd0);
    check("mid_rst_data_byte", {24'b0, data_byte}, 32'd0);
    check("mid_rst_bc", {{(32-CNT_W){1'b0}}, byte_count}, 32'd0);
    check("mid_rst_vld", {31'b0, data_byte_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // First packet after reset
    exp_pkt(0, 1, 8'hD2, 0, 0, 0, 0, 0, 0);
    send_byte(8'h80); send_byte(8'hD2); send_eop();
    idle(5);

    check("pkt_queue_drained", exp_q.size(), 32'd0);
    check("byte_queue_drained", byte_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
